// File: rtl/controle_multiplicador_seq_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
// FSM states use fixed encodings so that waveforms and debug tools agree on them.
package controle_multiplicador_seq_pkg;

  localparam int LARGURA_PADRAO   = 8;
  localparam int BITS_CONT_PADRAO = 4;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    SOMA    = 3'd1,
    DESLOCA = 3'd2,
    FIM     = 3'd3
  } estado_t;

endpackage

// File: rtl/controle_multiplicador_seq_somador.sv
// Somador8bits: 8-bit ripple-carry adder, shared by every multiplier iteration.
module Somador8bits (
  output logic [7:0] s_o,
  output logic       cout_o,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i
);

  logic [8:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[8];

endmodule

// File: rtl/controle_multiplicador_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a start/done handshake.
// Fixed latency: one SOMA/DESLOCA pair per multiplier bit, then FIM loads P.
module controle_multiplicador_seq
  import controle_multiplicador_seq_pkg::*;
#(
  parameter int LARGURA   = LARGURA_PADRAO,
  parameter int BITS_CONT = BITS_CONT_PADRAO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     A,
  input  logic [LARGURA-1:0]     B,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [2*LARGURA-1:0]   P
);

  if (LARGURA != 8) begin : g_chk_largura
    $error("controle_multiplicador_seq: only LARGURA=8 is supported");
  end
  if ((1 << BITS_CONT) <= LARGURA) begin : g_chk_cont
    $error("controle_multiplicador_seq: BITS_CONT too small for LARGURA");
  end

  estado_t                estado_q, estado_d;
  logic [LARGURA-1:0]     m_q, m_d;
  logic [LARGURA-1:0]     h_q, h_d;
  logic [LARGURA-1:0]     q_q, q_d;
  logic                   c_q, c_d;
  logic [BITS_CONT-1:0]   cont_q, cont_d;
  logic [2*LARGURA-1:0]   p_q, p_d;
  logic                   pronto_q, pronto_d;
  logic                   ocupado_q, ocupado_d;

  logic [LARGURA-1:0]     soma;
  logic                   soma_cout;

  Somador8bits u_somador (
    .s_o    (soma),
    .cout_o (soma_cout),
    .a_i    (h_q),
    .b_i    (m_q),
    .cin_i  (1'b0)
  );

  always_comb begin
    estado_d = estado_q;
    m_d      = m_q;
    h_d      = h_q;
    q_d      = q_q;
    c_d      = c_q;
    cont_d   = cont_q;
    p_d      = p_q;
    pronto_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          m_d      = A;
          q_d      = B;
          h_d      = '0;
          c_d      = 1'b0;
          cont_d   = '0;
          estado_d = SOMA;
        end
      end
      SOMA: begin
        if (q_q[0]) {c_d, h_d} = {soma_cout, soma};
        else        c_d = 1'b0;
        estado_d = DESLOCA;
      end
      DESLOCA: begin
        // Carry enters the top of H so the 9-bit partial sum is never lost.
        {c_d, h_d, q_d} = {1'b0, c_q, h_q, q_q[LARGURA-1:1]};
        cont_d   = cont_q + BITS_CONT'(1);
        estado_d = (cont_q == BITS_CONT'(LARGURA - 1)) ? FIM : SOMA;
      end
      FIM: begin
        p_d      = {h_q, q_q};
        pronto_d = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      m_q       <= '0;
      h_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cont_q    <= '0;
      p_q       <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      m_q       <= m_d;
      h_q       <= h_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cont_q    <= cont_d;
      p_q       <= p_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign P       = p_q;

endmodule

// File: tb/tb_controle_multiplicador_seq.sv
// Scoreboard bench: a timing/arithmetic model pushes A*B per accepted job; a monitor
// pops on every pronto pulse and also checks ocupado/pronto/P cycle by cycle.
module tb_controle_multiplicador_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic [7:0]  A, B;
  logic        ocupado, pronto;
  logic [15:0] P;

  controle_multiplicador_seq dut (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .A       (A),
    .B       (B),
    .ocupado (ocupado),
    .pronto  (pronto),
    .P       (P)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] prod;
    int          epoch;
  } job_t;

  job_t sb[$];

  // Model state (written only by the model process)
  int          ecount = 0;
  int          epoch = 0;
  bit          job_active = 1'b0;
  int          job_e0 = 0;
  logic [15:0] job_prod = '0;
  int          nacc = 0;
  int          nabort = 0;
  bit          exp_busy = 1'b0;
  bit          exp_pronto = 1'b0;
  logic [15:0] exp_p = '0;

  // Monitor state
  int nvec = 0;
  int nmis = 0;
  int npronto = 0;
  bit done = 1'b0;

  // Job accepted at edge e0: busy after edges e0..e0+16, pronto after e0+17,
  // next request can be taken at edge e0+18.
  always @(posedge clk) begin
    int d;
    ecount++;
    if (rst) begin
      if (job_active && (ecount - job_e0) <= 17) nabort++;
      job_active = 1'b0;
      epoch++;
      exp_p = '0;
    end else begin
      if (job_active && (ecount - job_e0) == 17) exp_p = job_prod;
      if ((!job_active || (ecount - job_e0) >= 18) && inicio) begin
        job_active = 1'b1;
        job_e0     = ecount;
        job_prod   = 16'(A) * 16'(B);
        nacc++;
        sb.push_back('{prod: job_prod, epoch: epoch});
      end
    end
    d          = job_active ? (ecount - job_e0) : 1000;
    exp_busy   = (d <= 16);
    exp_pronto = (d == 17);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  initial begin
    job_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      chk("ocupado", 32'(ocupado), 32'(exp_busy));
      chk("pronto", 32'(pronto), 32'(exp_pronto));
      chk("P_hold", 32'(P), 32'(exp_p));
      if (pronto === 1'b1) begin
        npronto++;
        while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
        if (sb.size() == 0) chk("pronto_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("product", 32'(P), 32'(e.prod));
        end
      end
    end
    while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
    chk("jobs_left", 32'(sb.size()), 32'd0);
    chk("pronto_count", 32'(npronto), 32'(nacc - nabort));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b);
    A = a; B = b; inicio = 1'b1;
    cyc();
    inicio = 1'b0;
  endtask

  task automatic job(input logic [7:0] a, input logic [7:0] b);
    start(a, b);
    repeat (19) cyc();
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; A = '0; B = '0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    job(8'h0D, 8'h0B);
    job(8'hFF, 8'hFF);
    job(8'h80, 8'h02);
    job(8'h00, 8'hFF);

    // Request during busy is ignored; operand changes do not disturb the job
    start(8'h0D, 8'h0B);
    repeat (4) cyc();
    A = 8'hFF; B = 8'hFF; inicio = 1'b1;
    cyc();
    inicio = 1'b0;
    repeat (16) cyc();

    // Abort mid-job, then a fresh job
    start(8'h0D, 8'h0B);
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    job(8'h03, 8'h05);

    // Back-to-back: second request lands in the pronto cycle
    start(8'h21, 8'h07);
    repeat (17) cyc();
    start(8'hC4, 8'h3B);
    repeat (19) cyc();

    // inicio held high with operands changing every cycle
    for (int i = 0; i < 60; i++) begin
      inicio = 1'b1; A = 8'($urandom); B = 8'($urandom);
      cyc();
    end
    inicio = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      inicio = ($urandom_range(0, 3) == 0);
      A      = 8'($urandom);
      B      = 8'($urandom);
      rst    = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; inicio = 1'b0;
    repeat (25) cyc();
    done = 1'b1;
  end

endmodule
